acorn_ct_tag_collector: RTL and testbench
=========================================

Name: acorn_ct_tag_collector

Overview:
- Downstream of the encryption control stage in the ACORN-128 datapath.
- Per cipher step, XORs the plaintext bit from that stage with the keystream bit from the state-update core, and assembles the 128-bit ciphertext.
- Then captures the final 128 keystream bits of finalization as the tag.
- Presents {ciphertext, tag} on a valid/ready output handshake and flags step-sequence errors.

Parameters:
- IDX_W, 12, width of step index (matches cipher step counter).
- CT_START, 384, step index of first plaintext/ciphertext bit.
- CT_LEN, 128, number of ciphertext bits.
- TAG_START, 1408, step index of first tag keystream bit. Constraints: TAG_START >= CT_START+CT_LEN, and TAG_START+127 < 2^IDX_W.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- start  in  1  one-cycle pulse: clear registers, arm collection.
- step_valid  in  1  a cipher step completes this cycle.
- step_idx  in  IDX_W  index of the step qualified by step_valid.
- ks_bit  in  1  keystream bit of this step.
- mbit_in  in  1  plaintext bit of this step (aligned with step_idx).
- ct_data  out  128  ciphertext; first captured bit at [127].
- tag_data  out  128  tag; first captured bit at [127].
- out_valid  out  1  ct_data/tag_data complete and held.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- busy  out  1  high in any state except IDLE.
- err_seq  out  1  sticky sequence error.

Behaviour:
- Reset (rst==0 at a clock edge): state IDLE; ct_data=0, tag_data=0, out_valid=0, busy=0, err_seq=0; internal bit counter=0.
- States: IDLE, CT_WAIT, CT_COLLECT, TAG_WAIT, TAG_COLLECT, HOLD.
- IDLE:
  - start -> CT_WAIT; clears ct_data, tag_data, err_seq and counter.
  - step_valid is ignored.
- CT_WAIT:
  - step_valid with step_idx==CT_START captures bit 0 and moves to CT_COLLECT, expected index = CT_START+1.
  - step_valid with step_idx > CT_START sets err_seq and returns to IDLE.
  - Lower indices are ignored.
- Capture (both collect states): each accepted step shifts left by one, inserting the new bit at [0]. After N bits the first bit sits at [N-1]; after 128 bits the first bit is at [127].
  - Ciphertext bit = mbit_in XOR ks_bit.
  - Tag bit = ks_bit.
- CT_COLLECT:
  - Each step_valid must carry the expected index, otherwise set err_seq and go to IDLE; partial ct_data is retained.
  - After the 128th bit (step_idx==CT_START+127), go to TAG_WAIT.
- TAG_WAIT:
  - step_valid with step_idx==TAG_START captures the first tag bit and moves to TAG_COLLECT.
  - step_idx > TAG_START is an error (err_seq, go to IDLE).
  - Indices between the ciphertext window and TAG_START are ignored (padding/finalization steps).
- TAG_COLLECT:
  - Same index checking as CT_COLLECT.
  - After bit 128 (step_idx==TAG_START+127), go to HOLD; out_valid=1 from the next cycle.
- HOLD:
  - Outputs stable; step_valid ignored.
  - out_valid && out_ready -> IDLE; out_valid falls the following cycle.
  - out_ready may be high before out_valid; the handshake completes in the first HOLD cycle.
- Gaps: cycles with step_valid==0 are allowed anywhere and do not advance state.
- Simultaneous events:
  - start with step_valid in the same cycle: start wins, step not captured.
  - start in any non-IDLE state: restart (-> CT_WAIT, clear everything, out_valid drops next cycle).
  - Reset mid-operation: immediate return to reset values at that edge.
- err_seq: sticky until start or reset. ct_data/tag_data keep their partial values for debug. out_valid is never asserted on an errored run.
- busy = (state != IDLE); it is registered along with the state.
- Latency: out_valid rises 1 cycle after the edge that captures the last tag bit.

Test Plan:
- Nominal run: start; steps 0..1535 back-to-back, mbit=1 for even idx, ks=idx[0]^idx[3], out_ready=1 -> out_valid pulses one cycle after step 1535; ct_data/tag_data equal the model MSB-first vectors; err_seq=0.
- Backpressure: same run with out_ready=0 for 20 cycles after out_valid -> outputs and out_valid held stable 20 cycles; IDLE 1 cycle after out_ready=1; steps sent during HOLD are ignored.
- Gapped steps: random step_valid idles (~50% duty) -> identical ct_data/tag_data to the nominal run.
- Sequence error: skip index 400 (jump 399->401) -> err_seq=1 next cycle, state IDLE, no out_valid; next start clears err_seq.
- Restart and reset: start mid-CT_COLLECT at step 450 -> busy stays 1, ct_data=0 next cycle, fresh run completes correctly. rst=0 during TAG_COLLECT -> all outputs 0 at that edge.
- Start/step collision: start and step_valid(idx=384) in the same cycle -> bit not captured; a repeated step 384 is then captured as bit 0.

Source files
------------

// File: rtl/acorn_ct_tag_collector.sv
// ACORN-128 ciphertext/tag collector: XORs plaintext with keystream into
// a 128-bit ciphertext, captures the final keystream bits as the tag.
module acorn_ct_tag_collector #(
  parameter int IDX_W     = 12,
  parameter int CT_START  = 384,
  parameter int CT_LEN    = 128,
  parameter int TAG_START = 1408
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_valid,
  input  logic [IDX_W-1:0] step_idx,
  input  logic             ks_bit,
  input  logic             mbit_in,
  output logic [127:0]     ct_data,
  output logic [127:0]     tag_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err_seq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CT_WAIT,
    S_CT_COLLECT,
    S_TAG_WAIT,
    S_TAG_COLLECT,
    S_HOLD
  } state_t;

  localparam logic [IDX_W-1:0] LP_CT0  = IDX_W'(CT_START);
  localparam logic [IDX_W-1:0] LP_TAG0 = IDX_W'(TAG_START);
  localparam logic [7:0] LP_CT_LAST    = 8'(CT_LEN - 1);
  localparam logic [7:0] LP_TAG_LAST   = 8'd127;

  state_t             r_state;
  logic [127:0]       r_ct;
  logic [127:0]       r_tag;
  logic               r_valid;
  logic               r_busy;
  logic               r_err;
  logic [7:0]         r_cnt;

  logic [IDX_W-1:0]   w_base;
  logic [IDX_W-1:0]   w_exp;
  logic               w_hit;
  logic               w_ctb;

  // Index the current collect window expects next
  always_comb begin
    w_base = (r_state == S_TAG_COLLECT) ? LP_TAG0 : LP_CT0;
    w_exp  = w_base + IDX_W'(r_cnt);
    w_hit  = (step_idx == w_exp);
    w_ctb  = mbit_in ^ ks_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ct    <= '0;
      r_tag   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (start) begin
      r_state <= S_CT_WAIT;
      r_ct    <= '0;
      r_tag   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b1;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_CT_WAIT: begin
          if (step_valid) begin
            if (step_idx == LP_CT0) begin
              r_ct    <= {r_ct[126:0], w_ctb};
              r_cnt   <= 8'd1;
              r_state <= S_CT_COLLECT;
            end else if (step_idx > LP_CT0) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_CT_COLLECT: begin
          if (step_valid) begin
            if (w_hit) begin
              r_ct <= {r_ct[126:0], w_ctb};
              if (r_cnt == LP_CT_LAST) begin
                r_cnt   <= '0;
                r_state <= S_TAG_WAIT;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end else begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_TAG_WAIT: begin
          if (step_valid) begin
            if (step_idx == LP_TAG0) begin
              r_tag   <= {r_tag[126:0], ks_bit};
              r_cnt   <= 8'd1;
              r_state <= S_TAG_COLLECT;
            end else if (step_idx > LP_TAG0) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_TAG_COLLECT: begin
          if (step_valid) begin
            if (w_hit) begin
              r_tag <= {r_tag[126:0], ks_bit};
              if (r_cnt == LP_TAG_LAST) begin
                r_cnt   <= '0;
                r_valid <= 1'b1;
                r_state <= S_HOLD;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end else begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (r_valid && out_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ct_data   = r_ct;
  assign tag_data  = r_tag;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign err_seq   = r_err;

endmodule

// File: tb/tb_acorn_ct_tag_collector.sv
// Directed bench for acorn_ct_tag_collector: vector table plus
// multi-cycle sequences checked against a bit-level model.
module tb_acorn_ct_tag_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         step_valid;
  logic [11:0]  step_idx;
  logic         ks_bit;
  logic         mbit_in;
  logic [127:0] ct_data;
  logic [127:0] tag_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         err_seq;

  int total = 0;
  int bad   = 0;

  logic [127:0] ct_exp;
  logic [127:0] tag_exp;

  acorn_ct_tag_collector dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .step_valid (step_valid),
    .step_idx   (step_idx),
    .ks_bit     (ks_bit),
    .mbit_in    (mbit_in),
    .ct_data    (ct_data),
    .tag_data   (tag_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err_seq    (err_seq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sv;
    logic [11:0] idx;
    logic        ks;
    logic        mb;
    logic        e_busy;
    logic        e_err;
    logic        e_valid;
    logic [3:0]  e_ct;
  } vec_t;

  vec_t vec [12];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic mb_of(input logic [11:0] i);
    return ~i[0];
  endfunction

  function automatic logic ks_of(input logic [11:0] i);
    return i[0] ^ i[3];
  endfunction

  task automatic send(input int i);
    logic [11:0] x;
    x = 12'(i);
    step_valid = 1'b1;
    step_idx   = x;
    mbit_in    = mb_of(x);
    ks_bit     = ks_of(x);
    tick();
    step_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends steps lo..hi; optional random idle cycles; notes early out_valid
  task automatic run(input int lo, input int hi, input bit gap,
                     output bit early);
    early = 1'b0;
    for (int i = lo; i <= hi; i++) begin
      if (gap && ($urandom_range(1) == 1)) tick();
      if (out_valid) early = 1'b1;
      send(i);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    bit early;
    logic [11:0] t;
    rst = 1'b0; start = 1'b0; step_valid = 1'b0; step_idx = '0;
    ks_bit = 1'b0; mbit_in = 1'b0; out_ready = 1'b1;

    for (int i = 0; i < 128; i++) begin
      t = 12'(384 + i);
      ct_exp[127 - i] = mb_of(t) ^ ks_of(t);
      t = 12'(1408 + i);
      tag_exp[127 - i] = ks_of(t);
    end

    vec[0]  = '{1'b1, 1'b1, 12'd384, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    vec[1]  = '{1'b0, 1'b1, 12'd384, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1};
    vec[2]  = '{1'b0, 1'b0, 12'd385, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1};
    vec[3]  = '{1'b0, 1'b1, 12'd385, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3};
    vec[4]  = '{1'b0, 1'b1, 12'd387, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3};
    vec[5]  = '{1'b0, 1'b1, 12'd386, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3};
    vec[6]  = '{1'b1, 1'b0, 12'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    vec[7]  = '{1'b0, 1'b1, 12'd100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    vec[8]  = '{1'b0, 1'b1, 12'd385, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    vec[9]  = '{1'b1, 1'b0, 12'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    vec[10] = '{1'b0, 1'b1, 12'd384, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    vec[11] = '{1'b0, 1'b1, 12'd385, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1};

    tick();
    tick();
    rst = 1'b1;
    chk("rst_ct", ct_data, '0);
    chk("rst_tag", tag_data, '0);
    chk("rst_flags", {125'd0, out_valid, busy, err_seq}, '0);

    // Per-cycle vectors: collision, gaps, index errors, sticky err
    for (int v = 0; v < 12; v++) begin
      start      = vec[v].st;
      step_valid = vec[v].sv;
      step_idx   = vec[v].idx;
      ks_bit     = vec[v].ks;
      mbit_in    = vec[v].mb;
      tick();
      chk($sformatf("vec%0d_busy", v), 128'(busy), 128'(vec[v].e_busy));
      chk($sformatf("vec%0d_err", v), 128'(err_seq), 128'(vec[v].e_err));
      chk($sformatf("vec%0d_valid", v), 128'(out_valid),
          128'(vec[v].e_valid));
      chk($sformatf("vec%0d_ct", v), 128'(ct_data[3:0]),
          128'(vec[v].e_ct));
    end
    start = 1'b0;
    step_valid = 1'b0;

    // Nominal back-to-back run
    do_reset();
    pulse_start();
    run(0, 1535, 1'b0, early);
    chk("nom_early", 128'(early), 0);
    chk("nom_valid", 128'(out_valid), 1);
    chk("nom_ct", ct_data, ct_exp);
    chk("nom_tag", tag_data, tag_exp);
    chk("nom_err", 128'(err_seq), 0);
    tick();
    chk("nom_valid_fall", 128'({out_valid, busy}), 0);

    // Backpressure with stray steps during HOLD
    pulse_start();
    out_ready = 1'b0;
    run(0, 1535, 1'b0, early);
    for (int c = 0; c < 20; c++) begin
      if (c < 5) send(1408 + c);
      else tick();
    end
    chk("bp_valid", 128'({out_valid, busy}), 128'(3));
    chk("bp_ct", ct_data, ct_exp);
    chk("bp_tag", tag_data, tag_exp);
    out_ready = 1'b1;
    tick();
    chk("bp_release", 128'({out_valid, busy}), 0);

    // Gapped steps
    pulse_start();
    run(0, 1535, 1'b1, early);
    chk("gap_early", 128'(early), 0);
    chk("gap_valid", 128'(out_valid), 1);
    chk("gap_ct", ct_data, ct_exp);
    chk("gap_tag", tag_data, tag_exp);
    tick();

    // Skipped index 400
    pulse_start();
    run(0, 399, 1'b0, early);
    send(401);
    chk("skip_err", 128'({err_seq, busy, out_valid}), 128'(4));
    run(402, 1535, 1'b0, early);
    chk("skip_novalid", 128'({early, out_valid, err_seq}), 128'(1));
    pulse_start();
    chk("skip_clear", 128'({err_seq, busy}), 128'(1));

    // Restart mid ciphertext collection
    run(0, 449, 1'b0, early);
    pulse_start();
    chk("restart_busy", 128'(busy), 1);
    chk("restart_ct", ct_data, '0);
    run(0, 1535, 1'b0, early);
    chk("restart_ct2", ct_data, ct_exp);
    chk("restart_tag", tag_data, tag_exp);
    chk("restart_valid", 128'(out_valid), 1);
    tick();

    // Reset during tag collection
    pulse_start();
    run(0, 1450, 1'b0, early);
    chk("pre_rst_busy", 128'(busy), 1);
    rst = 1'b0;
    tick();
    chk("midrst_ct", ct_data, '0);
    chk("midrst_tag", tag_data, '0);
    chk("midrst_flags", 128'({out_valid, busy, err_seq}), 0);
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
